// File: rtl/rf_write_arbiter_if.sv
// Requester/register-file bundle for rf_write_arbiter.
// The slave modport is the arbiter side.
interface rf_write_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              clr_req;
    logic              a_valid;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_rd;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_data;
    logic              clear_done;

    modport master (
        output clr_req, a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  a_ready, b_ready, rf_we, rf_rd, rf_data, clear_done
    );

    modport slave (
        input  clr_req, a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output a_ready, b_ready, rf_we, rf_rd, rf_data, clear_done
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-requester round-robin register-file write arbiter.
// Sweeps registers 1..NREGS-1 to zero after reset or on a clear request.
module rf_write_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREGS  = 32
) (
    input logic             i_clk,
    input logic             i_rst,
    rf_write_arbiter_if.slave bus
);
    localparam logic [ADDR_W-1:0] LastReg = ADDR_W'(NREGS - 1);

    typedef enum logic {StClear, StRun} state_e;

    state_e            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_last_b;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_rd;
    logic [DATA_W-1:0] r_rf_data;
    logic              r_clear_done;

    logic              w_run_ok;
    logic              w_grant_a;
    logic              w_grant_b;
    logic [ADDR_W-1:0] w_sel_rd;
    logic [DATA_W-1:0] w_sel_data;

    // On a tie, A wins only when B held the last grant.
    always_comb begin
        w_run_ok   = (r_state == StRun) && !bus.clr_req;
        w_grant_a  = w_run_ok && bus.a_valid && (!bus.b_valid || r_last_b);
        w_grant_b  = w_run_ok && bus.b_valid && !w_grant_a;
        w_sel_rd   = w_grant_a ? bus.a_rd : bus.b_rd;
        w_sel_data = w_grant_a ? bus.a_data : bus.b_data;
    end

    assign bus.a_ready    = w_grant_a;
    assign bus.b_ready    = w_grant_b;
    assign bus.rf_we      = r_rf_we;
    assign bus.rf_rd      = r_rf_rd;
    assign bus.rf_data    = r_rf_data;
    assign bus.clear_done = r_clear_done;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= StClear;
            r_cnt        <= ADDR_W'(1);
            r_last_b     <= 1'b1;
            r_rf_we      <= 1'b0;
            r_rf_rd      <= '0;
            r_rf_data    <= '0;
            r_clear_done <= 1'b0;
        end else begin
            r_clear_done <= (r_state == StRun);
            case (r_state)
                StClear: begin
                    r_rf_we   <= 1'b1;
                    r_rf_rd   <= r_cnt;
                    r_rf_data <= '0;
                    // Counter parks at the last register rather than wrapping.
                    if (r_cnt == LastReg) begin
                        r_state <= StRun;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StRun: begin
                    if (bus.clr_req) begin
                        r_state  <= StClear;
                        r_cnt    <= ADDR_W'(1);
                        r_last_b <= 1'b1;
                        r_rf_we  <= 1'b0;
                    end else if (w_grant_a || w_grant_b) begin
                        // Writes to the zero register are swallowed.
                        r_rf_we   <= (w_sel_rd != '0);
                        r_rf_rd   <= w_sel_rd;
                        r_rf_data <= w_sel_data;
                        r_last_b  <= w_grant_b;
                    end else begin
                        r_rf_we <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StClear;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: clear sweep, single writes, round-robin,
// zero-register writes, clear requests and mid-clear reset.
module tb_rf_write_arbiter;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    rf_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    rf_write_arbiter #(
        .DATA_W(32),
        .ADDR_W(5),
        .NREGS (32)
    ) u_dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clr_req = 1'b0;
        bus.a_valid = 1'b0;
        bus.a_rd    = '0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_rd    = '0;
        bus.b_data  = '0;
    endtask

    // Checks one full clear sweep; optionally pulses clr_req mid-sweep.
    task automatic check_sweep(input string tag, input bit poke_clr);
        for (int i = 1; i <= 31; i++) begin
            tick();
            bus.clr_req = 1'b0;
            check({tag, "_we"}, 64'(bus.rf_we), 64'd1);
            check({tag, "_rd"}, 64'(bus.rf_rd), 64'(i));
            check({tag, "_data"}, 64'(bus.rf_data), 64'd0);
            if (i < 31) begin
                check({tag, "_ardy"}, 64'(bus.a_ready), 64'd0);
                check({tag, "_brdy"}, 64'(bus.b_ready), 64'd0);
            end
            if (poke_clr && i == 10) bus.clr_req = 1'b1;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        #1;
        check("rst_we", 64'(bus.rf_we), 64'd0);
        check("rst_rd", 64'(bus.rf_rd), 64'd0);
        check("rst_data", 64'(bus.rf_data), 64'd0);
        check("rst_done", 64'(bus.clear_done), 64'd0);
        check("rst_ardy", 64'(bus.a_ready), 64'd0);
        check("rst_brdy", 64'(bus.b_ready), 64'd0);
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        check_sweep("clr0", 1'b0);
        check("clr0_done_lag", 64'(bus.clear_done), 64'd0);
        tick();
        check("clr0_done", 64'(bus.clear_done), 64'd1);
        check("clr0_idle_we", 64'(bus.rf_we), 64'd0);

        // Single A write.
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'd5;
        bus.a_data  = 32'hDEADBEEF;
        #1;
        check("a1_ardy", 64'(bus.a_ready), 64'd1);
        check("a1_brdy", 64'(bus.b_ready), 64'd0);
        tick();
        bus.a_valid = 1'b0;
        check("a1_we", 64'(bus.rf_we), 64'd1);
        check("a1_rd", 64'(bus.rf_rd), 64'd5);
        check("a1_data", 64'(bus.rf_data), 64'hDEADBEEF);
        tick();
        check("a1_we_off", 64'(bus.rf_we), 64'd0);
        check("a1_rd_hold", 64'(bus.rf_rd), 64'd5);
        check("a1_data_hold", 64'(bus.rf_data), 64'hDEADBEEF);

        // B write to register 0: handshake but no write.
        bus.b_valid = 1'b1;
        bus.b_rd    = 5'd0;
        bus.b_data  = 32'h1234;
        #1;
        check("z_brdy", 64'(bus.b_ready), 64'd1);
        check("z_ardy", 64'(bus.a_ready), 64'd0);
        tick();
        bus.b_valid = 1'b0;
        check("z_we", 64'(bus.rf_we), 64'd0);

        // Round-robin with both valid; last grant was B so A goes first.
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'd3;
        bus.a_data  = 32'hA3A3A3A3;
        bus.b_valid = 1'b1;
        bus.b_rd    = 5'd4;
        bus.b_data  = 32'hB4B4B4B4;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_ardy", 64'(bus.a_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
            check("rr_brdy", 64'(bus.b_ready), (k % 2 == 1) ? 64'd1 : 64'd0);
            tick();
            check("rr_we", 64'(bus.rf_we), 64'd1);
            check("rr_rd", 64'(bus.rf_rd), (k % 2 == 0) ? 64'd3 : 64'd4);
            check("rr_data", 64'(bus.rf_data),
                  (k % 2 == 0) ? 64'hA3A3A3A3 : 64'hB4B4B4B4);
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        tick();
        check("rr_we_off", 64'(bus.rf_we), 64'd0);

        // A write so that last grant is A before the clear request.
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'd7;
        bus.a_data  = 32'h77;
        #1;
        check("a2_ardy", 64'(bus.a_ready), 64'd1);
        tick();
        bus.a_valid = 1'b0;
        check("a2_rd", 64'(bus.rf_rd), 64'd7);

        // Clear request with both pending.
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'd9;
        bus.a_data  = 32'h99;
        bus.b_valid = 1'b1;
        bus.b_rd    = 5'd10;
        bus.b_data  = 32'hAA;
        bus.clr_req = 1'b1;
        #1;
        check("cq_ardy", 64'(bus.a_ready), 64'd0);
        check("cq_brdy", 64'(bus.b_ready), 64'd0);
        tick();
        bus.clr_req = 1'b0;
        check("cq_we", 64'(bus.rf_we), 64'd0);
        check("cq_ardy2", 64'(bus.a_ready), 64'd0);
        check_sweep("clr1", 1'b1);
        #1;
        check("cq_first_a", 64'(bus.a_ready), 64'd1);
        check("cq_first_b", 64'(bus.b_ready), 64'd0);
        tick();
        bus.a_valid = 1'b0;
        check("cq_a_rd", 64'(bus.rf_rd), 64'd9);
        check("cq_a_data", 64'(bus.rf_data), 64'h99);
        #1;
        check("cq_b_rdy", 64'(bus.b_ready), 64'd1);
        tick();
        bus.b_valid = 1'b0;
        check("cq_b_rd", 64'(bus.rf_rd), 64'd10);
        check("cq_b_data", 64'(bus.rf_data), 64'hAA);

        // Reset in the middle of a clear sweep.
        tick();
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int i = 1; i <= 10; i++) tick();
        check("mr_rd10", 64'(bus.rf_rd), 64'd10);
        check("mr_we10", 64'(bus.rf_we), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_we", 64'(bus.rf_we), 64'd0);
        check("mr_done", 64'(bus.clear_done), 64'd0);
        check("mr_rd", 64'(bus.rf_rd), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("mr_restart_we", 64'(bus.rf_we), 64'd1);
            check("mr_restart_rd", 64'(bus.rf_rd), 64'(i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001: Parameters (name, default, meaning): DATA_W, 32, write data width.
REQ-002: ADDR_W, 5, register address width.
REQ-003: NREGS, 32, register count; register 0 is hardwired zero.
REQ-004: Ports (name, direction, width, meaning): clk, input, 1, single clock; all state is rising-edge.
REQ-005: rst, input, 1, asynchronous active-low reset.
REQ-006: clr_req, input, 1, one-cycle pulse requesting a full register clear.
REQ-007: a_valid, input, 1, requester A (writeback) has a write pending.
REQ-008: a_rd, input, ADDR_W, requester A destination register.
REQ-009: a_data, input, DATA_W, requester A write data.
REQ-010: a_ready, output, 1, requester A is granted this cycle.
REQ-011: b_valid, input, 1, requester B (load/debug) has a write pending.
REQ-012: b_rd, input, ADDR_W, requester B destination register.
REQ-013: b_data, input, DATA_W, requester B write data.
REQ-014: b_ready, output, 1, requester B is granted this cycle.
REQ-015: rf_we, output, 1, register file write enable.
REQ-016: rf_rd, output, ADDR_W, register file write address.
REQ-017: rf_data, output, DATA_W, register file write data.
REQ-018: clear_done, output, 1, high while the block is in RUN.

Function
REQ-019: The FSM SHALL have two states, CLEAR and RUN, and a clear counter cnt of width ADDR_W.
REQ-020: In CLEAR, the block SHALL register rf_we=1, rf_rd=cnt and rf_data=0 each cycle, then increment cnt.
REQ-021: After the cycle that issues cnt=NREGS-1, the FSM SHALL enter RUN, so one clear takes NREGS-1 cycles.
REQ-022: In CLEAR, a_ready and b_ready SHALL both be 0.
REQ-023: In RUN, when clr_req=1, the block SHALL grant no requester that cycle, set cnt to 1 and enter CLEAR on the next edge.
REQ-024: In RUN with clr_req=0, a_ready and b_ready SHALL be combinational from the valid inputs, the state and the last_grant flag.
REQ-025: At most one of a_ready and b_ready SHALL be high in any cycle.
REQ-026: If exactly one of a_valid and b_valid is high, that requester SHALL be granted.
REQ-027: If both are high, the requester other than last_grant SHALL be granted (round-robin).
REQ-028: last_grant SHALL update only on a grant.
REQ-029: A handshake SHALL complete when valid and ready are both high.
REQ-030: A requester SHALL hold valid, rd and data stable until its handshake completes; the bench checks this.
REQ-031: Write latency SHALL be 1 cycle: a grant at cycle N produces rf_we, rf_rd and rf_data from the granted requester at cycle N+1, for exactly one cycle.
REQ-032: A granted request with rd=0 SHALL complete its handshake but SHALL drive rf_we=0.
REQ-033: In RUN with no grant, rf_we SHALL be 0, and rf_rd and rf_data SHALL hold their last values.
REQ-034: In CLEAR, cnt SHALL never wrap; the counter stops at NREGS-1.
REQ-035: clr_req received while already in CLEAR SHALL be ignored.
REQ-036: clear_done SHALL be a registered output equal to (state==RUN).

Reset
REQ-037: Asserting rst low SHALL immediately force state=CLEAR, cnt=1, rf_we=0, rf_rd=0, rf_data=0, last_grant=B and clear_done=0.
REQ-038: Reset asserted mid-clear SHALL abandon the sequence; on release the clear SHALL restart from register 1.
REQ-039: Because last_grant resets to B, the first tie after a clear SHALL be granted to A.
REQ-040: a_ready and b_ready SHALL be 0 throughout reset.

Verification
REQ-041: Release reset with both valid inputs low -> 31 consecutive cycles with rf_we=1, rf_rd=1..31 and rf_data=0. clear_done rises the cycle after rf_rd=31, and both ready outputs stay 0 throughout.
REQ-042: In RUN, drive a_valid=1, a_rd=5, a_data=0xDEADBEEF -> a_ready=1 in the same cycle. Next cycle rf_we=1, rf_rd=5, rf_data=0xDEADBEEF, then rf_we=0.
REQ-043: Hold both valids high for 6 cycles with a_rd=3 and b_rd=4 -> grant order A,B,A,B,A,B. rf_rd sequence is 3,4,3,4,3,4, each lagging its grant by one cycle.
REQ-044: Request b_rd=0 with b_data=0x1234 -> b_ready=1 and the handshake completes, but rf_we stays 0 the following cycle.
REQ-045: Pulse clr_req while both valids are high -> no grant that cycle, followed by a 31-cycle clear. Both requests remain pending, and the first grant afterwards goes to A.
REQ-046: Assert rst low when rf_rd=10 during a clear -> rf_we=0 and clear_done=0 immediately. After release, rf_rd restarts at 1.
